texture_cache_assoc: RTL



---
 rtl/tcache_pkg.sv | 14 +
 rtl/texture_cache_way.sv | 52 +++++
 rtl/texture_cache_assoc.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/tcache_pkg.sv
// Shared types and default widths for the set-associative texture line cache.
package tcache_pkg;

  localparam int unsigned TC_LINE_W = 256;
  localparam int unsigned TC_ADDR_W = 39;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } tc_state_e;

endpackage

// File: rtl/texture_cache_way.sv
// One way of the texture cache: per-set valid bit, tag and line data.
// Writes land on the clock edge; the lookup port is combinational.
module texture_cache_way
  import tcache_pkg::*;
#(
  parameter int unsigned LINE_W   = TC_LINE_W,
  parameter int unsigned ADDR_W   = TC_ADDR_W,
  parameter int unsigned SETS_LOG = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [SETS_LOG-1:0]          wr_set,
  input  logic [ADDR_W-SETS_LOG-1:0]   wr_tag,
  input  logic [LINE_W-1:0]            wr_data,
  input  logic [SETS_LOG-1:0]          rd_set,
  input  logic [ADDR_W-SETS_LOG-1:0]   rd_tag,
  output logic                         rd_match_c,
  output logic [LINE_W-1:0]            rd_data_c
);

  localparam int unsigned SETS  = 1 << SETS_LOG;
  localparam int unsigned TAG_W = ADDR_W - SETS_LOG;

  logic              valid_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS];
  logic [LINE_W-1:0] data_q  [SETS];

  // Valid bits: flush wins over a write on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= 1'b0;
    end else if (flush) begin
      for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= 1'b0;
    end else if (wr_en) begin
      valid_q[wr_set] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_set]  <= wr_tag;
      data_q[wr_set] <= wr_data;
    end
  end

  assign rd_match_c = valid_q[rd_set] && (tag_q[rd_set] == rd_tag);
  assign rd_data_c  = data_q[rd_set];

endmodule

// File: rtl/texture_cache_assoc.sv
// Set-associative texture line cache with round-robin replacement, a
// registered one-cycle hit path and a single outstanding L2 miss.
// Optional hit/miss counters are built when TCACHE_STATS_EN is defined.
module texture_cache_assoc
  import tcache_pkg::*;
#(
  parameter int unsigned LINE_W   = TC_LINE_W,
  parameter int unsigned ADDR_W   = TC_ADDR_W,
  parameter int unsigned SETS_LOG = 2,
  parameter int unsigned WAYS     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              except,
  input  logic              read_clkEn,
  input  logic [ADDR_W-1:0] read_addr,
  output logic              read_ready,
  output logic              read_valid,
  output logic              read_hit,
  output logic [LINE_W-1:0] read_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rdy,
  input  logic [LINE_W-1:0] mem_data
`ifdef TCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int unsigned SETS  = 1 << SETS_LOG;
  localparam int unsigned VP_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TAG_W = ADDR_W - SETS_LOG;

  tc_state_e         state_q;
  tc_state_e         state_nxt;

  logic              accept;
  logic              hit_any;
  logic              hit_rsp;
  logic              miss_start;
  logic              fill_we;

  logic [SETS_LOG-1:0] rd_set;
  logic [SETS_LOG-1:0] fill_set;
  logic [TAG_W-1:0]    rd_tag;
  logic [TAG_W-1:0]    fill_tag;

  logic [WAYS-1:0]   way_match;
  logic [WAYS-1:0]   way_we;
  logic [LINE_W-1:0] way_data [WAYS];
  logic [LINE_W-1:0] hit_data;

  logic [VP_W-1:0]   victim_q [SETS];
  logic [VP_W-1:0]   fill_victim;

  assign rd_set      = read_addr[SETS_LOG-1:0];
  assign rd_tag      = read_addr[ADDR_W-1:SETS_LOG];
  assign fill_set    = mem_addr[SETS_LOG-1:0];
  assign fill_tag    = mem_addr[ADDR_W-1:SETS_LOG];
  assign fill_victim = victim_q[fill_set];

  assign accept  = read_clkEn & read_ready & ~except;
  assign hit_any = |way_match;

  // Way array; only the way selected by the set's victim pointer takes a fill.
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_we[w] = fill_we && (fill_victim == VP_W'(w));

    texture_cache_way #(
      .LINE_W   (LINE_W),
      .ADDR_W   (ADDR_W),
      .SETS_LOG (SETS_LOG)
    ) u_way (
      .clk        (clk),
      .rst        (rst),
      .flush      (except),
      .wr_en      (way_we[w]),
      .wr_set     (fill_set),
      .wr_tag     (fill_tag),
      .wr_data    (mem_data),
      .rd_set     (rd_set),
      .rd_tag     (rd_tag),
      .rd_match_c (way_match[w]),
      .rd_data_c  (way_data[w])
    );
  end

  // Hit data select; at most one way matches, so an OR of gated ways suffices.
  always_comb begin
    hit_data = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_match[w]) hit_data = hit_data | way_data[w];
    end
  end

  // State register plus the state-decoded handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      read_ready <= 1'b1;
      mem_req    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      read_ready <= (state_nxt == S_IDLE);
      mem_req    <= (state_nxt == S_REQ);
    end
  end

  // Next-state logic; data already returned alongside except ends the miss.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !hit_any) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (mem_ack && mem_rdy)  state_nxt = S_IDLE;
        else if (mem_ack)        state_nxt = except ? S_DRAIN : S_WAIT;
        else if (except)         state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (mem_rdy)             state_nxt = S_IDLE;
        else if (except)         state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (mem_rdy)             state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-cycle actions: hit response, miss launch and fill write.
  always_comb begin
    hit_rsp    = 1'b0;
    miss_start = 1'b0;
    fill_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        hit_rsp    = accept & hit_any;
        miss_start = accept & ~hit_any;
      end
      S_REQ:   fill_we = mem_ack & mem_rdy & ~except;
      S_WAIT:  fill_we = mem_rdy & ~except;
      default: ;
    endcase
  end

  // Miss address latch; held stable for the whole REQ phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             mem_addr <= '0;
    else if (miss_start) mem_addr <= read_addr;
  end

  // Round-robin victim pointers; advance only on an actual fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) victim_q[s] <= '0;
    end else if (fill_we && (WAYS > 1)) begin
      victim_q[fill_set] <= fill_victim + VP_W'(1);
    end
  end

  // Registered response: hit data or the fill data passed straight through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_valid <= 1'b0;
      read_hit   <= 1'b0;
      read_data  <= '0;
    end else begin
      read_valid <= hit_rsp | fill_we;
      read_hit   <= hit_rsp;
      if (hit_rsp)      read_data <= hit_data;
      else if (fill_we) read_data <= mem_data;
    end
  end

`ifdef TCACHE_STATS_EN
  // Saturating hit/miss counters; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits   <= 32'd0;
      stat_misses <= 32'd0;
    end else begin
      if (hit_rsp && (stat_hits != 32'hFFFF_FFFF))      stat_hits   <= stat_hits + 32'd1;
      if (miss_start && (stat_misses != 32'hFFFF_FFFF)) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule
